noc_local_endpoint: RTL and testbench
=====================================

Name: noc_local_endpoint

Overview:
- Network-side endpoint that attaches to a router's local (L) port.
- Transmit direction: buffers client flits and injects them into the router's local input FIFO under credit-based flow control.
- Receive direction: accepts flits from the router's local output port, buffers them for the client, and returns one credit per flit the client consumes.
- This block is the counterpart that drives and sinks the router's local credit/enable/data interface.

Parameters:
CREDITS, 4, depth of the router's local input FIFO; initial and maximum TX credit count.
TX_DEPTH, 4, client-side transmit FIFO entries (power of 2, >=2).
RX_DEPTH, 4, receive FIFO entries; must be >= the router's local output credit count.

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  asynchronous, active-low reset.
tx_data_i  input  16  client flit; [7:4] destination X, [3:0] destination Y, [15:8] payload.
tx_valid_i  input  1  client flit valid.
tx_ready_o  output  1  TX FIFO can accept; push = tx_valid_i & tx_ready_o.
net_data_o  output  16  flit to router local input.
net_enable_o  output  1  one-cycle write strobe to router local input.
net_credit_i  input  1  one-cycle credit-return pulse from router (one slot freed).
net_data_i  input  16  flit from router local output.
net_enable_i  input  1  write strobe from router local output.
net_credit_o  output  1  one-cycle credit-return pulse to router.
rx_data_o  output  16  head of RX FIFO (show-ahead).
rx_valid_o  output  1  RX FIFO non-empty.
rx_ready_i  input  1  client pop; pop = rx_valid_o & rx_ready_i.
credits_o  output  $clog2(CREDITS+1)  current TX credit count.
err_o  output  2  sticky: [0] RX overflow, [1] credit overflow.

Behaviour:
Reset (rst=0, asynchronous):
- Both FIFOs emptied; credit counter = CREDITS.
- net_enable_o=0, net_data_o=0, net_credit_o=0, rx_valid_o=0, rx_data_o=0, err_o=0.
- tx_ready_o is forced 0 while rst=0.
- Mid-operation reset discards queued flits and in-flight credits; the router must be reset together with this block.

TX path:
- tx_ready_o = (tx_count != TX_DEPTH).
- A push that coincides with a pop while full is refused; readiness is decided on the current count.
- Send condition, evaluated each edge: TX FIFO non-empty AND credit count > 0 AND rst high.
- When the send condition holds, the registered outputs become net_enable_o=1 and net_data_o=head for exactly one cycle; the head is popped and credits decrement.
- When the send condition does not hold: net_enable_o=0 and net_data_o holds its last value.
- Latency: a flit accepted at edge t is visible at the head after t. With credits available, net_enable_o=1 in the cycle following edge t+1.
- Back-to-back sends occur every cycle while flits and credits remain.
- Credit update:
  - net_credit_i alone: +1.
  - send alone: -1.
  - both in the same cycle: unchanged.
- A credit arriving while the count = CREDITS and no send occurs is ignored and sets err_o[1].
- Count never exceeds CREDITS and never goes below 0.
- FIFO order is strict FIFO; TX pointers wrap modulo TX_DEPTH.

RX path:
- net_enable_i=1 at an edge writes net_data_i into the RX FIFO.
- A write while full with no simultaneous pop is dropped and sets err_o[0].
- A write while full with a simultaneous pop is accepted.
- rx_valid_o = non-empty; rx_data_o = head. Both update combinationally from FIFO state, so new data is visible the cycle after the write edge.
- Pop at edge t → net_credit_o=1 during the cycle after t, for exactly one cycle per pop.
- Consecutive pops give consecutive credit pulses.
- Credits are never returned for dropped flits.

TX and RX paths are fully independent; simultaneous activity on both paths has no interaction.

Test Plan:
1. Reset with CREDITS=4 → credits_o=4, tx_ready_o=1 after release, all strobes 0. Push 0x0012 → net_enable_o=1 with net_data_o=0x0012 exactly one cycle, 2 cycles after the push; credits_o=3.
2. Push 6 flits 0x0A01..0x0A06 with no net_credit_i → exactly 4 sends in order 0x0A01..0x0A04, credits_o=0. TX holds 2 flits; tx_ready_o=1 until 2 more are pushed (count=4), then 0.
3. From credits_o=0 with flits queued, pulse net_credit_i once → exactly one send next cycle. Then assert net_credit_i in the same cycle as a send → credits_o unchanged.
4. At credits_o=4, TX empty, pulse net_credit_i → credits_o stays 4, err_o=2'b10.
5. Router writes 0x1234, 0x5678; client holds rx_ready_i=1 → rx_data_o shows 0x1234 then 0x5678, each followed by one net_credit_o pulse (2 pulses total, 1 cycle after each pop).
6. RX_DEPTH=4, rx_ready_i=0, five writes → first 4 retained, 5th dropped, err_o[0]=1, no net_credit_o. Then assert rst mid-stream → rx_valid_o=0, err_o=0, credits_o=4 immediately (asynchronous).

Source files
------------

// File: rtl/noc_local_endpoint.sv
// Router local-port endpoint: credit-flow TX injection and buffered RX with
// per-flit credit return toward the router.
module noc_local_endpoint #(
  parameter int CREDITS  = 4,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  output logic [15:0]                  net_data_o,
  output logic                         net_enable_o,
  input  logic                         net_credit_i,
  input  logic [15:0]                  net_data_i,
  input  logic                         net_enable_i,
  output logic                         net_credit_o,
  output logic [15:0]                  rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic [$clog2(CREDITS+1)-1:0] credits_o,
  output logic [1:0]                   err_o
);

  localparam int CW  = $clog2(CREDITS + 1);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = $clog2(RX_DEPTH + 1);

  function automatic logic [TAW-1:0] tx_inc(input logic [TAW-1:0] p);
    return (p == TAW'(TX_DEPTH - 1)) ? '0 : p + TAW'(1);
  endfunction

  function automatic logic [RAW-1:0] rx_inc(input logic [RAW-1:0] p);
    return (p == RAW'(RX_DEPTH - 1)) ? '0 : p + RAW'(1);
  endfunction

  // TX state
  logic [15:0]    tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_wp_d;
  logic [TAW-1:0] tx_rp_q, tx_rp_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]  cred_q, cred_d;
  logic [15:0]    net_data_q;
  logic           net_en_q;
  logic           tx_push;
  logic           tx_send;
  logic           crd_err;

  // RX state
  logic [15:0]    rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_wp_d;
  logic [RAW-1:0] rx_rp_q, rx_rp_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic           net_cr_q;
  logic [1:0]     err_q, err_d;
  logic           rx_full;
  logic           rx_pop;
  logic           rx_wr;
  logic           rx_drop;

  assign tx_ready_o = rst & (tx_cnt_q != TCW'(TX_DEPTH));
  assign tx_push    = tx_valid_i & tx_ready_o;
  assign tx_send    = (tx_cnt_q != '0) & (cred_q != '0);

  always_comb begin
    tx_wp_d  = tx_push ? tx_inc(tx_wp_q) : tx_wp_q;
    tx_rp_d  = tx_send ? tx_inc(tx_rp_q) : tx_rp_q;
    tx_cnt_d = tx_cnt_q + TCW'(tx_push) - TCW'(tx_send);
  end

  // A credit landing with a send cancels out; a surplus one is an error.
  always_comb begin
    cred_d  = cred_q;
    crd_err = 1'b0;
    unique case (1'b1)
      net_credit_i & ~tx_send: begin
        if (cred_q == CW'(CREDITS)) crd_err = 1'b1;
        else                        cred_d  = cred_q + CW'(1);
      end
      tx_send & ~net_credit_i: cred_d = cred_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= tx_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      cred_q     <= CW'(CREDITS);
      net_en_q   <= 1'b0;
      net_data_q <= '0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      cred_q   <= cred_d;
      net_en_q <= tx_send;
      if (tx_send) net_data_q <= tx_mem_q[tx_rp_q];
    end
  end

  assign net_enable_o = net_en_q;
  assign net_data_o   = net_data_q;
  assign credits_o    = cred_q;

  assign rx_valid_o = (rx_cnt_q != '0);
  assign rx_data_o  = rx_valid_o ? rx_mem_q[rx_rp_q] : '0;
  assign rx_full    = (rx_cnt_q == RCW'(RX_DEPTH));
  assign rx_pop     = rx_valid_o & rx_ready_i;
  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign rx_wr      = net_enable_i & (~rx_full | rx_pop);
  assign rx_drop    = net_enable_i & rx_full & ~rx_pop;

  always_comb begin
    rx_wp_d  = rx_wr  ? rx_inc(rx_wp_q) : rx_wp_q;
    rx_rp_d  = rx_pop ? rx_inc(rx_rp_q) : rx_rp_q;
    rx_cnt_d = rx_cnt_q + RCW'(rx_wr) - RCW'(rx_pop);
    err_d    = err_q | {crd_err, rx_drop};
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem_q[rx_wp_q] <= net_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      net_cr_q <= 1'b0;
      err_q    <= '0;
    end else begin
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      net_cr_q <= rx_pop;
      err_q    <= err_d;
    end
  end

  assign net_credit_o = net_cr_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_noc_local_endpoint.sv
// Scoreboard bench for noc_local_endpoint: queue-level reference model,
// directed scenarios followed by randomized traffic on both paths.
module tb_noc_local_endpoint;

  localparam int CREDITS = 4;
  localparam int TXD     = 4;
  localparam int RXD     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] tx_data_i = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [15:0] net_data_o;
  logic        net_enable_o;
  logic        net_credit_i = 1'b0;
  logic [15:0] net_data_i = '0;
  logic        net_enable_i = 1'b0;
  logic        net_credit_o;
  logic [15:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic [2:0]  credits_o;
  logic [1:0]  err_o;

  noc_local_endpoint #(
    .CREDITS(CREDITS), .TX_DEPTH(TXD), .RX_DEPTH(RXD)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .net_data_o(net_data_o), .net_enable_o(net_enable_o),
    .net_credit_i(net_credit_i),
    .net_data_i(net_data_i), .net_enable_i(net_enable_i),
    .net_credit_o(net_credit_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .credits_o(credits_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: FIFOs as queues, credits as a plain integer.
  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  logic [15:0] sb_tx[$];
  int          m_cred = CREDITS;
  logic [1:0]  m_err = '0;
  bit          m_en = 0;
  bit          m_cp = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tx.delete();
      m_rx.delete();
      sb_tx.delete();
      m_cred = CREDITS;
      m_err  = '0;
      m_en   = 0;
      m_cp   = 0;
    end else begin
      bit rdy, snd, pop;
      rdy  = m_tx.size() < TXD;
      snd  = m_tx.size() > 0 && m_cred > 0;
      m_en = snd;
      if (snd) sb_tx.push_back(m_tx.pop_front());
      if (tx_valid_i && rdy) m_tx.push_back(tx_data_i);
      if (net_credit_i && !snd) begin
        if (m_cred == CREDITS) m_err[1] = 1'b1;
        else m_cred++;
      end else if (snd && !net_credit_i) begin
        m_cred--;
      end
      pop  = m_rx.size() > 0 && rx_ready_i;
      m_cp = pop;
      if (pop) void'(m_rx.pop_front());
      if (net_enable_i) begin
        if (m_rx.size() < RXD) m_rx.push_back(net_data_i);
        else m_err[0] = 1'b1;
      end
    end
  end

  // Monitor: compares the DUT against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      chk("net_enable", net_enable_o, m_en);
      if (net_enable_o) begin
        if (sb_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_sb: unexpected flit %h, none expected",
                   net_data_o);
        end else begin
          chk("net_data", net_data_o, sb_tx.pop_front());
        end
      end
      chk("credits", credits_o, m_cred);
      chk("err", err_o, m_err);
      chk("tx_ready", tx_ready_o, m_tx.size() < TXD);
      chk("rx_valid", rx_valid_o, m_rx.size() > 0);
      if (m_rx.size() > 0) chk("rx_data", rx_data_o, m_rx[0]);
      chk("net_credit", net_credit_o, m_cp);
      if (net_credit_o) cp_cnt++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] d);
    int n = 0;
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    while (!tx_ready_o && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: flit %h never accepted", d);
    end
    cyc();
    tx_valid_i = 1'b0;
  endtask

  initial begin
    int c0;
    cyc(2);
    chk("rst_tx_ready", tx_ready_o, 0);
    chk("rst_credits", credits_o, CREDITS);
    chk("rst_net_en", net_enable_o, 0);
    chk("rst_net_data", net_data_o, 0);
    chk("rst_net_credit", net_credit_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b1;
    #1;
    chk("rel_tx_ready", tx_ready_o, 1);

    // Single flit latency
    tx_data_i  = 16'h0012;
    tx_valid_i = 1'b1;
    cyc();
    tx_valid_i = 1'b0;
    chk("t1_en_early", net_enable_o, 0);
    cyc();
    chk("t1_en", net_enable_o, 1);
    chk("t1_data", net_data_o, 16'h0012);
    chk("t1_credits", credits_o, 3);
    cyc();
    chk("t1_en_once", net_enable_o, 0);

    net_credit_i = 1'b1;
    cyc();
    net_credit_i = 1'b0;
    cyc();

    // Credit exhaustion
    for (int i = 1; i <= 6; i++) push(16'h0A00 + 16'(i));
    cyc(3);
    chk("t2_credits", credits_o, 0);
    chk("t2_ready", tx_ready_o, 1);
    push(16'h0A07);
    chk("t2_ready_3", tx_ready_o, 1);
    push(16'h0A08);
    chk("t2_ready_full", tx_ready_o, 0);

    // Credit return, then credit coincident with a send
    net_credit_i = 1'b1;
    cyc();
    net_credit_i = 1'b0;
    chk("t3_en_wait", net_enable_o, 0);
    cyc();
    chk("t3_en", net_enable_o, 1);
    chk("t3_data", net_data_o, 16'h0A05);
    cyc();
    chk("t3_single", net_enable_o, 0);
    net_credit_i = 1'b1;
    cyc(2);
    chk("t3_same_cred", credits_o, 1);
    chk("t3_same_en", net_enable_o, 1);
    net_credit_i = 1'b0;
    cyc();
    net_credit_i = 1'b1;
    cyc(5);
    net_credit_i = 1'b0;
    cyc(2);

    // Credit overflow
    chk("t4_pre_cred", credits_o, CREDITS);
    chk("t4_pre_err", err_o, 2'b00);
    net_credit_i = 1'b1;
    cyc();
    net_credit_i = 1'b0;
    chk("t4_cred", credits_o, CREDITS);
    chk("t4_err", err_o, 2'b10);

    // RX with client always ready
    c0 = cp_cnt;
    rx_ready_i   = 1'b1;
    net_enable_i = 1'b1;
    net_data_i   = 16'h1234;
    cyc();
    chk("t5_head0", rx_data_o, 16'h1234);
    net_data_i = 16'h5678;
    cyc();
    net_enable_i = 1'b0;
    chk("t5_head1", rx_data_o, 16'h5678);
    chk("t5_cr0", net_credit_o, 1);
    cyc(4);
    chk("t5_pulses", cp_cnt - c0, 2);
    rx_ready_i = 1'b0;

    // RX overflow then asynchronous reset
    push(16'h0C01);
    cyc(2);
    c0 = cp_cnt;
    net_enable_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      net_data_i = 16'hB000 + 16'(i);
      cyc();
    end
    net_enable_i = 1'b0;
    cyc();
    chk("t6_head", rx_data_o, 16'hB001);
    chk("t6_err", err_o, 2'b11);
    chk("t6_no_cr", cp_cnt - c0, 0);
    chk("t6_pre_cred", credits_o, 3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", rx_valid_o, 0);
    chk("t6_rst_err", err_o, 0);
    chk("t6_rst_cred", credits_o, CREDITS);
    chk("t6_rst_ready", tx_ready_o, 0);
    cyc(2);
    rst = 1'b1;

    // Randomized traffic on both paths
    for (int i = 0; i < 3000; i++) begin
      tx_valid_i   = 1'($urandom_range(0, 1));
      tx_data_i    = 16'($urandom);
      net_credit_i = ($urandom_range(0, 2) == 0);
      net_enable_i = 1'($urandom_range(0, 1));
      net_data_i   = 16'($urandom);
      rx_ready_i   = 1'($urandom_range(0, 1));
      cyc();
    end
    tx_valid_i   = 1'b0;
    net_credit_i = 1'b0;
    net_enable_i = 1'b0;
    rx_ready_i   = 1'b1;
    cyc(10);
    @(negedge clk);
    #1;
    chk("sb_drain", sb_tx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
